// File: rtl/hcsr04_pkg.sv
// hcsr04_pkg
//   Definitions shared by the HC-SR04 echo emulator and the sensor driver:
//   FSM state encodings, default protocol timing constants and a helper
//   that sizes counters from a set of cycle parameters.
package hcsr04_pkg;

  // Emulator FSM states. Three bits leave two illegal encodings, which the
  // FSM treats as a request to return to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_TRIG_HIGH  = 3'd1,
    ST_TRIG_STUCK = 3'd2,
    ST_BURST      = 3'd3,
    ST_ECHO       = 3'd4,
    ST_HOLDOFF    = 3'd5
  } hcsr04_state_e;

  // Default timing, in clock cycles.
  localparam int TRIG_PULSE_CYCLES   = 10;     // nominal trig width from the driver
  localparam int ECHO_TIMEOUT_CYCLES = 25000;  // longest echo the driver waits for
  localparam int MEAS_PERIOD_CYCLES  = 50000;  // driver measurement repetition period

  // Largest of five cycle counts; used to size a counter shared by all phases.
  function automatic int max_cycles(input int a, input int b, input int c,
                                    input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Single-bit two-flop synchronizer for bringing an asynchronous level into
//   the clk domain. Both flops clear to 0 on reset.
// Ports:
//   clk  in  system clock
//   rst  in  asynchronous reset, active-high
//   d_i  in  asynchronous input level
//   q_o  out synchronized level (two clk edges of latency)
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/hcsr04_echo_emulator.sv
// hcsr04_echo_emulator
//   Stands in for an HC-SR04 ultrasonic sensor. A trig pulse of valid width
//   is followed, after a fixed burst delay, by an echo pulse whose length
//   (in cycles) encodes the emulated distance.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous reset, active-high
//   en         in   1 = accept new trig requests (looked at in IDLE only)
//   trig       in   asynchronous trigger from the ranging initiator
//   echo_width in   requested echo high time, latched when a trig is accepted
//   no_object  in   latched with echo_width; 1 = echo of MAX_ECHO_CYCLES
//   echo       out  registered echo pulse
//   busy       out  1 whenever the FSM is not in IDLE
//   trig_err   out  1-cycle pulse for a trig that is too short or stuck high
//   meas_done  out  1-cycle pulse on the cycle echo falls
//   state_dbg  out  current FSM state encoding, for observation only
module hcsr04_echo_emulator
  import hcsr04_pkg::*;
#(
  parameter int MIN_TRIG_CYCLES    = TRIG_PULSE_CYCLES,
  parameter int MAX_TRIG_CYCLES    = 1000,
  parameter int BURST_DELAY_CYCLES = 400,
  parameter int MAX_ECHO_CYCLES    = ECHO_TIMEOUT_CYCLES,
  parameter int HOLDOFF_CYCLES     = 5000,
  localparam int EW = $clog2(MAX_ECHO_CYCLES + 1),
  localparam int CW = $clog2(max_cycles(MIN_TRIG_CYCLES, MAX_TRIG_CYCLES,
                                        BURST_DELAY_CYCLES, MAX_ECHO_CYCLES,
                                        HOLDOFF_CYCLES) + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          trig,
  input  logic [EW-1:0] echo_width,
  input  logic          no_object,
  output logic          echo,
  output logic          busy,
  output logic          trig_err,
  output logic          meas_done,
  output logic [2:0]    state_dbg
);

  hcsr04_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [EW-1:0] width_q, width_d;
  logic          echo_q, echo_d;
  logic          trig_err_q, trig_err_d;
  logic          meas_done_q, meas_done_d;
  logic          trig_prev_q;
  logic          trig_s;
  logic          trig_rise;
  logic [EW-1:0] width_m1;

  sync_2ff u_trig_sync (
    .clk (clk),
    .rst (rst),
    .d_i (trig),
    .q_o (trig_s)
  );

  // The previous-sample register runs in every state, so a trig that is
  // already high when the FSM reaches IDLE never looks like a new edge.
  assign trig_rise = trig_s & ~trig_prev_q;

  // Echo ends on the cycle the counter reaches W-1; W is never 0.
  assign width_m1 = width_q - EW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      width_q     <= '0;
      echo_q      <= 1'b0;
      trig_err_q  <= 1'b0;
      meas_done_q <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      width_q     <= width_d;
      echo_q      <= echo_d;
      trig_err_q  <= trig_err_d;
      meas_done_q <= meas_done_d;
      trig_prev_q <= trig_s;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    width_d     = width_q;
    echo_d      = 1'b0;
    trig_err_d  = 1'b0;
    meas_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (trig_rise && en) begin
          state_d = ST_TRIG_HIGH;
          cnt_d   = CW'(1);
        end
      end

      // cnt holds the number of cycles trig_s has been seen high.
      ST_TRIG_HIGH: begin
        if (trig_s) begin
          if (cnt_q == CW'(MAX_TRIG_CYCLES - 1)) begin
            trig_err_d = 1'b1;
            state_d    = ST_TRIG_STUCK;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (cnt_q >= CW'(MIN_TRIG_CYCLES)) begin
          state_d = ST_BURST;
          cnt_d   = '0;
          if (no_object) begin
            width_d = EW'(MAX_ECHO_CYCLES);
          end else if (echo_width == '0) begin
            width_d = EW'(1);
          end else if (echo_width > EW'(MAX_ECHO_CYCLES)) begin
            width_d = EW'(MAX_ECHO_CYCLES);
          end else begin
            width_d = echo_width;
          end
        end else begin
          trig_err_d = 1'b1;
          state_d    = ST_IDLE;
          cnt_d      = '0;
        end
      end

      ST_TRIG_STUCK: begin
        if (!trig_s) begin
          state_d = ST_IDLE;
        end
      end

      ST_BURST: begin
        if (cnt_q == CW'(BURST_DELAY_CYCLES - 1)) begin
          echo_d  = 1'b1;
          state_d = ST_ECHO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_ECHO: begin
        if (cnt_q == CW'(width_m1)) begin
          meas_done_d = 1'b1;
          state_d     = ST_HOLDOFF;
          cnt_d       = '0;
        end else begin
          echo_d = 1'b1;
          cnt_d  = cnt_q + CW'(1);
        end
      end

      ST_HOLDOFF: begin
        if (cnt_q == CW'(HOLDOFF_CYCLES - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign echo      = echo_q;
  assign trig_err  = trig_err_q;
  assign meas_done = meas_done_q;
  assign busy      = (state_q != ST_IDLE);
  assign state_dbg = state_q;

endmodule
